// File: rtl/spi_serf.sv
// SPI responder for the 16-bit monarch: SCLK idles high, both ends sample on SCLK rise, MSB first.
// Optional `SPI_SERF_FRAME_ERR_EN adds a frame_err pulse for short/over-length frames.
module spi_serf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic             wrt,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
`ifdef SPI_SERF_FRAME_ERR_EN
  output logic             frame_err,
`endif
  input  logic             clr_rdy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic ss_s1_r, ss_s2_r, ss_s3_r;
  logic sclk_s1_r, sclk_s2_r, sclk_s3_r;
  logic mosi_s1_r, mosi_s2_r;
  logic [1:0] warm_r;
  logic armed_r;

  state_t          state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] tx_buf_r;
  logic [CW-1:0]   bit_cnt_r;
  logic            pend_r;
`ifdef SPI_SERF_FRAME_ERR_EN
  logic            over_r;
`endif

  logic sclk_rise_s, ss_fall_s, ss_rise_s;

  assign sclk_rise_s = sclk_s2_r & ~sclk_s3_r;
  assign ss_fall_s   = ~ss_s2_r & ss_s3_r & armed_r;
  assign ss_rise_s   = ss_s2_r & ~ss_s3_r;

  // Synchronisers; armed_r blocks a select fall until SS_n has truly been sampled high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_s1_r   <= 1'b1;
      ss_s2_r   <= 1'b1;
      ss_s3_r   <= 1'b1;
      sclk_s1_r <= 1'b1;
      sclk_s2_r <= 1'b1;
      sclk_s3_r <= 1'b1;
      mosi_s1_r <= 1'b0;
      mosi_s2_r <= 1'b0;
      warm_r    <= 2'd0;
      armed_r   <= 1'b0;
    end else begin
      ss_s1_r   <= SS_n;
      ss_s2_r   <= ss_s1_r;
      ss_s3_r   <= ss_s2_r;
      sclk_s1_r <= SCLK;
      sclk_s2_r <= sclk_s1_r;
      sclk_s3_r <= sclk_s2_r;
      mosi_s1_r <= MOSI;
      mosi_s2_r <= mosi_s1_r;
      warm_r    <= (warm_r == 2'd3) ? 2'd3 : warm_r + 2'd1;
      armed_r   <= armed_r | ((warm_r == 2'd3) & ss_s3_r);
    end
  end

  // Frame state machine, shift register, transmit buffer and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      tx_buf_r  <= '0;
      bit_cnt_r <= '0;
      pend_r    <= 1'b0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      MISO      <= 1'b0;
`ifdef SPI_SERF_FRAME_ERR_EN
      over_r    <= 1'b0;
      frame_err <= 1'b0;
`endif
    end else begin
      pend_r <= 1'b0;
`ifdef SPI_SERF_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (wrt) begin
        tx_buf_r <= tx_data;
      end else begin
        tx_buf_r <= tx_buf_r;
      end

      case (state_r)
        IDLE: begin
          if (ss_fall_s) begin
            shreg_r   <= wrt ? tx_data : tx_buf_r;
            bit_cnt_r <= '0;
            state_r   <= ACTIVE;
`ifdef SPI_SERF_FRAME_ERR_EN
            over_r    <= 1'b0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ACTIVE: begin
          if (ss_rise_s) begin
            state_r <= IDLE;
`ifdef SPI_SERF_FRAME_ERR_EN
            frame_err <= (bit_cnt_r != FULL) | over_r;
`endif
          end else if (sclk_rise_s) begin
            // Saturate at a full word; later rises in the same frame are dropped
            if (bit_cnt_r != FULL) begin
              shreg_r   <= {shreg_r[WIDTH-2:0], mosi_s2_r};
              bit_cnt_r <= bit_cnt_r + CW'(1);
              pend_r    <= (bit_cnt_r == FULL - CW'(1));
            end else begin
`ifdef SPI_SERF_FRAME_ERR_EN
              over_r <= 1'b1;
`endif
            end
          end else begin
            state_r <= ACTIVE;
          end
        end
        default: state_r <= IDLE;
      endcase

      if (pend_r) begin
        rx_data <= shreg_r;
      end else begin
        rx_data <= rx_data;
      end

      // Completion has priority over clr_rdy in the same clk
      if (pend_r) begin
        rdy <= 1'b1;
      end else if (clr_rdy || ((state_r == IDLE) && ss_fall_s)) begin
        rdy <= 1'b0;
      end else begin
        rdy <= rdy;
      end

      MISO <= ss_s3_r ? 1'b0 : shreg_r[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a behavioural monarch drives frames and checks both directions.
module tb_spi_serf;

  logic        clk;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        wrt;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rdy;
  logic        clr_rdy;
`ifdef SPI_SERF_FRAME_ERR_EN
  logic        frame_err;
`endif

  int tests_run;
  int tests_failed;
  int err_cnt;
  logic [15:0] resp;

  spi_serf #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .wrt(wrt), .tx_data(tx_data), .rx_data(rx_data), .rdy(rdy),
`ifdef SPI_SERF_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .clr_rdy(clr_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef SPI_SERF_FRAME_ERR_EN
  always @(posedge clk) if (frame_err) err_cnt++;
`endif

  // Stimulus changes on clk negedges (multiples of 10 ns), away from the active edge
  task automatic pulse_wrt(input logic [15:0] val);
    tx_data = val; wrt = 1'b1; #10; wrt = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1; #10; clr_rdy = 1'b0;
  endtask

  task automatic ss_low(input logic [15:0] cmd);
    MOSI = cmd[15]; SS_n = 1'b0; #40;
  endtask

  task automatic ss_high();
    #40; SS_n = 1'b1; #60;
  endtask

  // One SCLK period per bit: fall, 40 ns, rise (sample MISO), change MOSI mid-high phase
  task automatic shift(input logic [15:0] cmd, input int nbits, input int wrt_at,
                       input logic [15:0] wval, input bit clr_last, output logic [15:0] r);
    r = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      if (i == wrt_at) begin
        pulse_wrt(wval); #30;
      end else begin
        #40;
      end
      SCLK = 1'b1;
      r = {r[14:0], MISO};
      if (clr_last && (i == nbits - 1)) begin
        #30; pulse_clr();
      end else begin
        #20;
        if (i < 15) MOSI = cmd[14 - i];
        #20;
      end
    end
  endtask

  task automatic frame(input logic [15:0] cmd, output logic [15:0] r);
    ss_low(cmd);
    shift(cmd, 16, -1, 16'h0000, 1'b0, r);
    ss_high();
  endtask

  task automatic test_reset();
    if (MISO !== 1'b0) begin tests_failed++; $display("FAIL reset_miso got %b exp 0", MISO); end
    tests_run++;
    if (rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    tests_run++;
    if (rx_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_rx got %h exp 0000", rx_data); end
    tests_run++;
  endtask

  task automatic test_basic();
    pulse_wrt(16'hA5C3);
    frame(16'h1234, resp);
    if (resp !== 16'hA5C3) begin tests_failed++; $display("FAIL basic_resp got %h exp a5c3", resp); end
    tests_run++;
    if (rx_data !== 16'h1234) begin tests_failed++; $display("FAIL basic_rx got %h exp 1234", rx_data); end
    tests_run++;
    if (rdy !== 1'b1) begin tests_failed++; $display("FAIL basic_rdy got %b exp 1", rdy); end
    tests_run++;
  endtask

  task automatic test_back_to_back();
    frame(16'hFFFF, resp);
    if (rx_data !== 16'hFFFF) begin tests_failed++; $display("FAIL b2b_rx1 got %h exp ffff", rx_data); end
    tests_run++;
    if (resp !== 16'hA5C3) begin tests_failed++; $display("FAIL b2b_resp1 got %h exp a5c3", resp); end
    tests_run++;
    if (MISO !== 1'b0) begin tests_failed++; $display("FAIL b2b_miso_idle got %b exp 0", MISO); end
    tests_run++;
    ss_low(16'h0001);
    if (rdy !== 1'b0) begin tests_failed++; $display("FAIL b2b_rdy_clr got %b exp 0", rdy); end
    tests_run++;
    shift(16'h0001, 16, -1, 16'h0000, 1'b0, resp);
    ss_high();
    if (rdy !== 1'b1) begin tests_failed++; $display("FAIL b2b_rdy_set got %b exp 1", rdy); end
    tests_run++;
    if (rx_data !== 16'h0001) begin tests_failed++; $display("FAIL b2b_rx2 got %h exp 0001", rx_data); end
    tests_run++;
  endtask

  task automatic test_mid_wrt();
    pulse_wrt(16'h0F0F);
    ss_low(16'h3C3C);
    shift(16'h3C3C, 16, 8, 16'hBEEF, 1'b0, resp);
    ss_high();
    if (resp !== 16'h0F0F) begin tests_failed++; $display("FAIL mid_resp1 got %h exp 0f0f", resp); end
    tests_run++;
    if (rx_data !== 16'h3C3C) begin tests_failed++; $display("FAIL mid_rx1 got %h exp 3c3c", rx_data); end
    tests_run++;
    frame(16'hC3C3, resp);
    if (resp !== 16'hBEEF) begin tests_failed++; $display("FAIL mid_resp2 got %h exp beef", resp); end
    tests_run++;
    if (rx_data !== 16'hC3C3) begin tests_failed++; $display("FAIL mid_rx2 got %h exp c3c3", rx_data); end
    tests_run++;
  endtask

  task automatic test_short();
    pulse_clr();
    if (rdy !== 1'b0) begin tests_failed++; $display("FAIL short_clr got %b exp 0", rdy); end
    tests_run++;
    ss_low(16'hFFFF);
    shift(16'hFFFF, 9, -1, 16'h0000, 1'b0, resp);
    ss_high();
    if (rdy !== 1'b0) begin tests_failed++; $display("FAIL short_rdy got %b exp 0", rdy); end
    tests_run++;
    if (rx_data !== 16'hC3C3) begin tests_failed++; $display("FAIL short_rx got %h exp c3c3", rx_data); end
    tests_run++;
`ifdef SPI_SERF_FRAME_ERR_EN
    if (err_cnt !== 1) begin tests_failed++; $display("FAIL short_ferr got %0d exp 1", err_cnt); end
    tests_run++;
`endif
  endtask

  task automatic test_reset_mid();
    ss_low(16'hAAAA);
    shift(16'hAAAA, 5, -1, 16'h0000, 1'b0, resp);
    rst = 1'b1; #20;
    if (MISO !== 1'b0) begin tests_failed++; $display("FAIL rstmid_miso got %b exp 0", MISO); end
    tests_run++;
    if (rdy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rdy got %b exp 0", rdy); end
    tests_run++;
    if (rx_data !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_rx got %h exp 0000", rx_data); end
    tests_run++;
    rst = 1'b0; #60;
    // SS_n never seen high since reset: this whole word must be ignored
    shift(16'hFFFF, 16, -1, 16'h0000, 1'b0, resp);
    #60;
    if (rdy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_unarmed_rdy got %b exp 0", rdy); end
    tests_run++;
    SS_n = 1'b1; #100;
    frame(16'h5A5A, resp);
    if (rx_data !== 16'h5A5A) begin tests_failed++; $display("FAIL rstmid_rx2 got %h exp 5a5a", rx_data); end
    tests_run++;
    if (resp !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_resp got %h exp 0000", resp); end
    tests_run++;
    if (rdy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_rdy2 got %b exp 1", rdy); end
    tests_run++;
  endtask

  task automatic test_idle_noise();
    pulse_clr();
    for (int i = 0; i < 20; i++) begin
      SCLK = 1'b0; MOSI = ~MOSI; #40;
      SCLK = 1'b1; #40;
      if (MISO !== 1'b0) begin tests_failed++; $display("FAIL idle_miso[%0d] got %b exp 0", i, MISO); end
      tests_run++;
    end
    if (rdy !== 1'b0) begin tests_failed++; $display("FAIL idle_rdy got %b exp 0", rdy); end
    tests_run++;
    if (rx_data !== 16'h5A5A) begin tests_failed++; $display("FAIL idle_rx got %h exp 5a5a", rx_data); end
    tests_run++;
    // clr_rdy lands on the same clk as completion
    ss_low(16'h1111);
    shift(16'h1111, 16, -1, 16'h0000, 1'b1, resp);
    ss_high();
    if (rdy !== 1'b1) begin tests_failed++; $display("FAIL setclr_rdy got %b exp 1", rdy); end
    tests_run++;
    if (rx_data !== 16'h1111) begin tests_failed++; $display("FAIL setclr_rx got %h exp 1111", rx_data); end
    tests_run++;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; err_cnt = 0;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wrt = 1'b0; tx_data = 16'h0000; clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    #60;
    test_basic();
    test_back_to_back();
    test_mid_wrt();
    test_short();
    test_reset_mid();
    test_idle_noise();
`ifdef SPI_SERF_FRAME_ERR_EN
    if (err_cnt !== 1) begin tests_failed++; $display("FAIL final_ferr got %0d exp 1", err_cnt); end
    tests_run++;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
